// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel FSM state type,
// default parameter values and a constant helper for counter sizing.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_N_BTN           = 3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One debounced button channel: 2-flop synchronizer, debounce FSM and
// optional auto-repeat (enabled with macro BTN_REPEAT_EN).
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d, release_q, release_d;
  logic             accept_press, rep_pulse;

  // Stage 0: metastability synchronizer on the raw level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in_i;
      sync2_q <= sync1_q;
    end
  end

  // Stage 1: debounce FSM; a WAIT state bounces back on any cycle of the old level
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_press = 1'b0;
    release_d    = 1'b0;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      RELEASED: if (sync2_q) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LIM) begin
          state_d      = HELD;
          cnt_d        = '0;
          accept_press = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: if (!sync2_q) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LIM) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PERIOD);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic             rep_first_q, rep_first_d;

  // Repeat timer keeps running through RELEASE_WAIT and is suppressed on the release edge
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_pulse   = 1'b0;
    rep_inc     = (rep_cnt_q == CNT_MAX) ? rep_cnt_q : rep_cnt_q + 1'b1;
    if (accept_press) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (state_d == HELD || state_d == RELEASE_WAIT) begin
      if (rep_inc >= (rep_first_q ? DLY_LIM : PER_LIM)) begin
        rep_pulse   = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign press_d = accept_press | rep_pulse;

  // Stage 2: registered state and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent debounced button channels; auto-repeat is built only
// when macro BTN_REPEAT_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_in_i (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (N_BTN=3, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5); repeat expectations follow BTN_REPEAT_EN.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] btn_in;
  logic [2:0] btn_level, btn_press, btn_release;
  int checks;
  int failures;

  btn_conditioner #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle c of a window = negedge following the c-th rising edge after the stimulus change.
  task automatic test_reset;
    logic [2:0] ep, el, er;
    rst = 1'b1;
    btn_in = 3'b111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 3'b000 || btn_press !== 3'b000 || btn_release !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold k=%0d got lvl=%b prs=%b rel=%b exp all 000", k, btn_level, btn_press, btn_release);
      end
    end
    rst = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      ep = (c == 6) ? 3'b111 : 3'b000;
      el = (c >= 6) ? 3'b111 : 3'b000;
      checks++;
      if (btn_press !== ep || btn_level !== el || btn_release !== 3'b000) begin
        failures++;
        $display("FAIL reset_exit c=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=000", c, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_in = 3'b000;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      er = (c == 6) ? 3'b111 : 3'b000;
      el = (c >= 6) ? 3'b000 : 3'b111;
      checks++;
      if (btn_release !== er || btn_level !== el || btn_press !== 3'b000) begin
        failures++;
        $display("FAIL release_all c=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=000 rel=%b", c, btn_level, btn_press, btn_release, el, er);
      end
    end
  endtask

  task automatic test_clean_press;
    logic [2:0] ep, el, er;
    btn_in = 3'b001;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      ep = (c == 6) ? 3'b001 : 3'b000;
      el = (c >= 6) ? 3'b001 : 3'b000;
      checks++;
      if (btn_press !== ep || btn_level !== el || btn_release !== 3'b000) begin
        failures++;
        $display("FAIL clean_press c=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b", c, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_in = 3'b000;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      er = (c == 6) ? 3'b001 : 3'b000;
      el = (c >= 6) ? 3'b000 : 3'b001;
      checks++;
      if (btn_release !== er || btn_level !== el || btn_press !== 3'b000) begin
        failures++;
        $display("FAIL clean_release c=%0d got lvl=%b prs=%b rel=%b exp lvl=%b rel=%b", c, btn_level, btn_press, btn_release, el, er);
      end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] pattern;
    logic [2:0] ep;
    pattern = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      btn_in = {1'b0, pattern[k], 1'b0};
      @(negedge clk);
      checks++;
      if (btn_press !== 3'b000 || btn_level !== 3'b000) begin
        failures++;
        $display("FAIL bounce_early k=%0d got lvl=%b prs=%b exp 000", k, btn_level, btn_press);
      end
    end
    btn_in = 3'b010;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      ep = (c == 6) ? 3'b010 : 3'b000;
      checks++;
      if (btn_press !== ep || btn_release !== 3'b000) begin
        failures++;
        $display("FAIL bounce_press c=%0d got prs=%b rel=%b exp prs=%b rel=000", c, btn_press, btn_release, ep);
      end
    end
    btn_in = 3'b000;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (btn_release !== ((c == 6) ? 3'b010 : 3'b000)) begin
        failures++;
        $display("FAIL bounce_release c=%0d got rel=%b", c, btn_release);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [2:0] ep, er;
    btn_in = 3'b101;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      ep = (c == 6) ? 3'b101 : 3'b000;
      checks++;
      if (btn_press !== ep || btn_release !== 3'b000) begin
        failures++;
        $display("FAIL simul_press c=%0d got prs=%b rel=%b exp prs=%b rel=000", c, btn_press, btn_release, ep);
      end
    end
    btn_in = 3'b000;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      er = (c == 6) ? 3'b101 : 3'b000;
      checks++;
      if (btn_release !== er || btn_press !== 3'b000) begin
        failures++;
        $display("FAIL simul_release c=%0d got prs=%b rel=%b exp prs=000 rel=%b", c, btn_press, btn_release, er);
      end
    end
  endtask

  task automatic test_repeat;
    logic ep, er;
    btn_in = 3'b001;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
`ifdef BTN_REPEAT_EN
      ep = (c == 6) || (c >= 16 && c <= 41 && ((c - 16) % 5) == 0);
`else
      ep = (c == 6);
`endif
      er = (c == 46);
      checks++;
      if (btn_press[0] !== ep || btn_release[0] !== er) begin
        failures++;
        $display("FAIL repeat c=%0d got prs0=%b rel0=%b exp prs0=%b rel0=%b", c, btn_press[0], btn_release[0], ep, er);
      end
      if (c == 39) btn_in = 3'b000;
    end
  endtask

  task automatic test_reset_midwait;
    logic [2:0] ep, el;
    btn_in = 3'b001;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      ep = (c == 11) ? 3'b001 : 3'b000;
      el = (c >= 11) ? 3'b001 : 3'b000;
      checks++;
      if (btn_press !== ep || btn_level !== el || btn_release !== 3'b000) begin
        failures++;
        $display("FAIL reset_midwait c=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b", c, btn_level, btn_press, btn_release, el, ep);
      end
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
    end
    // Reset while held and released during reset: no release pulse may appear.
    rst = 1'b1;
    btn_in = 3'b000;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 3'b000 || btn_press !== 3'b000 || btn_release !== 3'b000) begin
        failures++;
        $display("FAIL reset_midhold c=%0d got lvl=%b prs=%b rel=%b exp all 000", c, btn_level, btn_press, btn_release);
      end
      if (c == 1) rst = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    btn_in = 3'b000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_repeat();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, 3, number of independent button channels (>=1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (>=1).
REQ-003 SHALL have parameter REPEAT_DELAY, 50000000, held cycles before the first auto-repeat pulse (>=1; used only with BTN_REPEAT_EN).
REQ-004 SHALL have parameter REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses (>=1; used only with BTN_REPEAT_EN).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port btn_in  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port btn_level  output  N_BTN  debounced level per channel.
REQ-009 SHALL have port btn_press  output  N_BTN  one-cycle pulse on accepted press (and on each repeat).
REQ-010 SHALL have port btn_release  output  N_BTN  one-cycle pulse on accepted release.

Function
REQ-011 Each channel SHALL pass btn_in through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run an FSM with states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 RELEASED->PRESS_WAIT when synchronized input = 1; HELD->RELEASE_WAIT when synchronized input = 0; counter cleared on entry.
REQ-014 In a WAIT state, counter SHALL increment each cycle the synchronized input holds the new value; any cycle it returns to the old value SHALL return to the previous stable state with counter cleared (bounce rejection).
REQ-015 When the counter reaches DEBOUNCE_CYCLES, the FSM SHALL enter HELD or RELEASED on that edge, updating btn_level and issuing btn_press or btn_release for exactly one cycle.
REQ-016 Latency from a clean raw transition to the btn_level/pulse update SHALL be exactly DEBOUNCE_CYCLES + 2 cycles.
REQ-017 btn_press and btn_release for the same channel SHALL never be high in the same cycle.
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce pulses in the same cycle with no arbitration.
REQ-019 Counter width SHALL be $clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, plus 1; counters SHALL saturate, never wrap.

Reset
REQ-020 While rst = 1, synchronizers, counters and FSMs SHALL clear; all FSMs SHALL enter RELEASED; btn_level, btn_press, btn_release SHALL be 0.
REQ-021 Reset mid-debounce or mid-hold SHALL discard the pending event with no release pulse; a button held across reset SHALL be re-debounced and produce one btn_press DEBOUNCE_CYCLES + 2 cycles after rst falls.

Configuration
REQ-022 With BTN_REPEAT_EN defined, a channel in HELD SHALL issue an extra btn_press pulse REPEAT_DELAY cycles after its accepted press, then every REPEAT_PERIOD cycles until it leaves HELD.
REQ-023 Repeat timing SHALL continue during RELEASE_WAIT bounce that returns to HELD; it SHALL stop on entry to RELEASED.
REQ-024 Without BTN_REPEAT_EN, no repeat counter SHALL be built, REPEAT_* parameters are ignored, exactly one btn_press per accepted press.

Structure
REQ-025 Shared package btn_pkg SHALL hold the channel-state enum type and default parameter constants.
REQ-026 Per-channel logic SHALL live in sub-module btn_channel, instanced N_BTN times by generate; btn_conditioner holds only instancing and bus wiring.

Verification (N_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-027 Reset: btn_in=3'b111 during rst -> all outputs 0 throughout rst; btn_level=3'b111 and btn_press=3'b111 for one cycle, 6 cycles after rst falls.
REQ-028 Clean press ch0 at cycle t -> btn_press[0] single pulse at t+6, btn_level[0]=1 from t+6; release at u -> btn_release[0] pulse at u+6.
REQ-029 Bounce ch1: high 3 cycles, low 1, high steady from t -> exactly one btn_press[1], at t+6.
REQ-030 Simultaneous press ch0 and ch2 at t -> btn_press=3'b101 at t+6, no other pulses.
REQ-031 BTN_REPEAT_EN, ch0 held from t for 40 cycles -> btn_press[0] at t+6, t+16, t+21, t+26, t+31, t+36, t+41; btn_release[0] at t+46; without the macro only t+6.
REQ-032 rst pulse at t+4 during PRESS_WAIT -> no pulse before reset; press pulse 6 cycles after rst falls if still held.
